// File: rtl/prog_mem_loader_if.sv
// Loader and fetch signal bundle for prog_mem_loader.
// The master side feeds chunks and fetch addresses; the slave side is the memory.
interface prog_mem_loader_if #(
    parameter int Psize = 5,
    parameter int Isize = 20,
    parameter int Csize = 8
);
    logic             start;
    logic             ld_valid;
    logic [Csize-1:0] ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             loaded;
    logic [Psize:0]   prog_count;
    logic [Psize-1:0] address;
    logic [Isize-1:0] I;
    logic             I_valid;

    modport master (
        output start, ld_valid, ld_data, ld_last, address,
        input  ld_ready, loaded, prog_count, I, I_valid
    );

    modport slave (
        input  start, ld_valid, ld_data, ld_last, address,
        output ld_ready, loaded, prog_count, I, I_valid
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Loadable program memory: assembles chunked instruction words into a RAM,
// then serves registered single-cycle fetches.
//
// state  | meaning
// S_LOAD | accepting loader chunks, fetch output forced to zero
// S_RUN  | program resident, serving fetches
module prog_mem_loader #(
    parameter int Psize = 5,
    parameter int Isize = 20,
    parameter int Csize = 8
) (
    input  logic                clk,
    input  logic                nReset,
    prog_mem_loader_if.slave    bus
);
    localparam int NCH   = (Isize + Csize - 1) / Csize;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 2 ** Psize;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [Psize:0]   r_wptr;
    logic [CW-1:0]    r_chunk;
    logic [Isize-1:0] r_asm;
    logic [Isize-1:0] r_mem [DEPTH];
    logic [Isize-1:0] r_instr;
    logic             r_ivalid;

    logic [Isize-1:0] w_word;
    logic             w_ready;
    logic             w_accept;
    logic             w_write;
    logic             w_full;
    logic             w_hit;

    assign w_ready  = (r_state == S_LOAD) && !bus.start;
    assign w_accept = bus.ld_valid && w_ready;
    assign w_write  = w_accept && ((r_chunk == CW'(NCH - 1)) || bus.ld_last);
    assign w_full   = (r_wptr == (Psize + 1)'(DEPTH - 1));
    assign w_hit    = ({1'b0, bus.address} < r_wptr);

    // Unreceived chunks read as zero because r_asm is cleared after every write.
    always_comb begin
        w_word = r_asm;
        for (int i = 0; i < Isize; i++) begin
            if ((i / Csize) == int'(r_chunk)) begin
                w_word[i] = bus.ld_data[i % Csize];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.start) begin
            w_next = S_LOAD;
        end else if ((r_state == S_LOAD) && w_write && (bus.ld_last || w_full)) begin
            w_next = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_LOAD;
            r_wptr   <= '0;
            r_chunk  <= '0;
            r_asm    <= '0;
            r_instr  <= '0;
            r_ivalid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (bus.start) begin
                r_wptr  <= '0;
                r_chunk <= '0;
                r_asm   <= '0;
            end else if (w_accept) begin
                if (w_write) begin
                    r_wptr  <= r_wptr + 1'b1;
                    r_chunk <= '0;
                    r_asm   <= '0;
                end else begin
                    r_chunk <= r_chunk + 1'b1;
                    r_asm   <= w_word;
                end
            end
            // Gating with start lets I_valid drop on the very next cycle of a restart.
            if ((r_state == S_RUN) && !bus.start) begin
                r_instr  <= w_hit ? r_mem[bus.address] : '0;
                r_ivalid <= 1'b1;
            end else begin
                r_instr  <= '0;
                r_ivalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr[Psize-1:0]] <= w_word;
        end
    end

    assign bus.ld_ready   = w_ready;
    assign bus.loaded     = (r_state == S_RUN);
    assign bus.prog_count = r_wptr;
    assign bus.I          = r_instr;
    assign bus.I_valid    = r_ivalid;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomised bench for prog_mem_loader against a word-level reference model.
module tb_prog_mem_loader;
    localparam int PS    = 5;
    localparam int IS    = 20;
    localparam int CS    = 8;
    localparam int NCH   = 3;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.Psize(PS), .Isize(IS), .Csize(CS)) bus ();

    prog_mem_loader #(.Psize(PS), .Isize(IS), .Csize(CS)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_mem [DEPTH];
    int          m_count  = 0;
    bit          m_run    = 0;
    logic [7:0]  q_chunk [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = 0;
        foreach (q_chunk[k]) w = w | (32'(q_chunk[k]) << (8 * k));
        return w & ((32'd1 << IS) - 1);
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic last);
        q_chunk.push_back(d);
        if (q_chunk.size() == NCH || last) begin
            m_mem[m_count] = model_word();
            m_count++;
            q_chunk.delete();
            if (last || m_count == DEPTH) m_run = 1;
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_run   = 0;
        q_chunk.delete();
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            bus.ld_last = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.ld_last = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic push(input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        #1;
        check("ld_ready", 32'(bus.ld_ready), 32'(!m_run));
        if (!m_run) model_accept(d, last);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = '0;
    endtask

    task automatic load_words(input logic [31:0] w[$], input bit gaps);
        logic [31:0] t;
        for (int j = 0; j < w.size(); j++) begin
            for (int k = 0; k < NCH; k++) begin
                t = w[j] >> (8 * k);
                push(t[7:0], (j == w.size() - 1) && (k == NCH - 1));
                if (gaps) idle_gap($urandom_range(0, 2));
            end
        end
    endtask

    task automatic fetch_seq(input int addrs[$]);
        logic [31:0] exp;
        bus.address = 5'(addrs[0]);
        for (int i = 1; i <= addrs.size(); i++) begin
            @(negedge clk);
            exp = (addrs[i-1] < m_count) ? m_mem[addrs[i-1]] : 32'd0;
            check($sformatf("I@%0d", addrs[i-1]), 32'(bus.I), exp);
            check("I_valid", 32'(bus.I_valid), 32'd1);
            if (i < addrs.size()) bus.address = 5'(addrs[i]);
        end
    endtask

    task automatic do_start();
        logic [31:0] r = $urandom;
        bus.start    = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = r[7:0];
        #1;
        check("ld_ready_start", 32'(bus.ld_ready), 32'd0);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        model_clear();
        check("loaded_after_start", 32'(bus.loaded), 32'd0);
        check("prog_count_after_start", 32'(bus.prog_count), 32'd0);
        check("I_valid_after_start", 32'(bus.I_valid), 32'd0);
    endtask

    task automatic check_loaded();
        check("loaded", 32'(bus.loaded), 32'(m_run));
        check("prog_count", 32'(bus.prog_count), 32'(m_count));
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] r;
        int          a[$];

        foreach (m_mem[i]) m_mem[i] = 0;
        nReset       = 1'b0;
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.address  = '0;
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_loaded", 32'(bus.loaded), 32'd0);
        check("rst_I", 32'(bus.I), 32'd0);
        check("rst_I_valid", 32'(bus.I_valid), 32'd0);
        check("rst_prog_count", 32'(bus.prog_count), 32'd0);

        // Three known words, then fetch including one past the program.
        w = '{32'h12345, 32'hABCDE, 32'h00001};
        load_words(w, 0);
        check_loaded();
        check("first_I_valid_delay", 32'(bus.I_valid), 32'd0);
        fetch_seq('{0, 1, 2, 3});

        // Partial final word is zero padded.
        do_start();
        push(8'h45, 1'b0);
        push(8'h23, 1'b1);
        check_loaded();
        fetch_seq('{0, 1});
        check("partial_word", 32'(m_mem[0]), 32'h02345);

        // Fill the whole array without ld_last.
        do_start();
        for (int i = 0; i < DEPTH * NCH; i++) begin
            r = $urandom;
            push(r[7:0], 1'b0);
        end
        #1;
        check("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        check_loaded();
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            push(r[7:0], 1'($urandom_range(0, 1)));
        end
        check_loaded();
        a.delete();
        a.push_back(31);
        for (int i = 0; i < 16; i++) a.push_back($urandom_range(0, DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) a.push_back(i);
        fetch_seq(a);

        // Restart with valid gaps and stray ld_last while not valid.
        do_start();
        w.delete();
        for (int i = 0; i < $urandom_range(4, 12); i++) w.push_back($urandom & 32'hFFFFF);
        load_words(w, 1);
        check_loaded();
        a.delete();
        for (int i = 0; i < DEPTH; i++) a.push_back(i);
        fetch_seq(a);

        // Reset in the middle of word 5.
        do_start();
        for (int i = 0; i < 4 * NCH + 2; i++) begin
            r = $urandom;
            push(r[7:0], 1'b0);
        end
        nReset = 1'b0;
        #1;
        model_clear();
        check("mid_rst_loaded", 32'(bus.loaded), 32'd0);
        check("mid_rst_prog_count", 32'(bus.prog_count), 32'd0);
        check("mid_rst_I", 32'(bus.I), 32'd0);
        check("mid_rst_I_valid", 32'(bus.I_valid), 32'd0);
        check("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        w.delete();
        w.push_back($urandom & 32'hFFFFF);
        w.push_back($urandom & 32'hFFFFF);
        load_words(w, 0);
        check_loaded();
        fetch_seq('{0, 1, 2, 4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
